// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX-stage issue logic and muldiv_unit.
// master = pipeline side, slave = muldiv_unit.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_in;
    logic [1:0]            op_in;
    logic [DATA_WIDTH-1:0] data1_in;
    logic [DATA_WIDTH-1:0] data2_in;
    logic                  hi_we_in;
    logic                  lo_we_in;
    logic [DATA_WIDTH-1:0] wdata_in;
    logic                  busy_out;
    logic                  done_out;
    logic                  div_by_zero_out;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    modport master (
        output start_in, op_in, data1_in, data2_in,
        output hi_we_in, lo_we_in, wdata_in,
        input  busy_out, done_out, div_by_zero_out,
        input  hi_out, lo_out
    );

    modport slave (
        input  start_in, op_in, data1_in, data2_in,
        input  hi_we_in, lo_we_in, wdata_in,
        output busy_out, done_out, div_by_zero_out,
        output hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO writes in IDLE.
// MULDIV_FAST_MULT_EN: single-cycle combinational multiply, divide unchanged.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    muldiv_unit_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]    op_q;
    logic [W-1:0]  mag_b;
    logic [W-1:0]  p_hi;
    logic [W-1:0]  p_lo;
    logic [W-1:0]  dvd_q;
    logic [CW-1:0] cnt;
    logic          neg_q;
    logic          rem_neg_q;
    logic          dz_q;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;
    logic          done_q;
    logic          dz_out_q;
    logic          busy;

    logic          accept;
    logic          is_div;
    logic          sgn_op;
    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic          fast;
    logic [2*W-1:0] fast_prod;

    assign accept = (state == IDLE) && bus.start_in;
    assign is_div = bus.op_in[1];
    assign sgn_op = ~bus.op_in[0];
    assign a_neg  = sgn_op & bus.data1_in[W-1];
    assign b_neg  = sgn_op & bus.data2_in[W-1];
    assign a_mag  = a_neg ? -bus.data1_in : bus.data1_in;
    assign b_mag  = b_neg ? -bus.data2_in : bus.data2_in;

`ifdef MULDIV_FAST_MULT_EN
    assign fast      = ~is_div;
    assign fast_prod = (2*W)'(a_mag) * (2*W)'(b_mag);
`else
    assign fast      = 1'b0;
    assign fast_prod = '0;
`endif

    // Shift-add multiply step: add multiplicand on low bit, shift right.
    logic [W:0]   add_sum;
    assign add_sum = p_lo[0] ? ({1'b0, p_hi} + {1'b0, mag_b})
                             : {1'b0, p_hi};

    // Restoring divide step: shift in next dividend bit, trial subtract.
    logic [W:0]   shifted;
    logic [W:0]   diff;
    logic         q_bit;
    logic [W-1:0] rem_nxt;
    assign shifted = {p_hi, p_lo[W-1]};
    assign diff    = shifted - {1'b0, mag_b};
    assign q_bit   = (shifted >= {1'b0, mag_b});
    assign rem_nxt = q_bit ? diff[W-1:0] : shifted[W-1:0];

    // Sign correction applied in FIX.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;
    logic           s_fix;
    assign s_fix    = ~op_q[0];
    assign prod_fix = (s_fix && neg_q) ? -{p_hi, p_lo} : {p_hi, p_lo};
    assign quo_fix  = (s_fix && neg_q) ? -p_lo : p_lo;
    assign rem_fix  = (s_fix && rem_neg_q) ? -p_hi : p_hi;

    always_comb begin
        res_hi = prod_fix[2*W-1:W];
        res_lo = prod_fix[W-1:0];
        if (op_q[1]) begin
            if (dz_q) begin
                res_hi = dvd_q;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start_in) state_nxt = fast ? FIX : RUN;
            RUN:  if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            op_q      <= '0;
            mag_b     <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
            dvd_q     <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (accept) begin
            op_q      <= bus.op_in;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dz_q      <= is_div && (bus.data2_in == '0);
            dvd_q     <= bus.data1_in;
            cnt       <= CW'(W);
            if (fast) begin
                mag_b <= a_mag;
                p_hi  <= fast_prod[2*W-1:W];
                p_lo  <= fast_prod[W-1:0];
            end else if (is_div) begin
                mag_b <= b_mag;
                p_hi  <= '0;
                p_lo  <= a_mag;
            end else begin
                mag_b <= a_mag;
                p_hi  <= '0;
                p_lo  <= b_mag;
            end
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            if (op_q[1]) begin
                p_hi <= rem_nxt;
                p_lo <= {p_lo[W-2:0], q_bit};
            end else begin
                p_hi <= add_sum[W:1];
                p_lo <= {add_sum[0], p_lo[W-1:1]};
            end
        end
    end

    // HI/LO: result in FIX wins; MTHI/MTLO only while idle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
        end else begin
            done_q   <= (state == FIX);
            dz_out_q <= (state == FIX) && op_q[1] && dz_q;
            if (state == FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state == IDLE) begin
                if (bus.hi_we_in) hi_q <= bus.wdata_in;
                if (bus.lo_we_in) lo_q <= bus.wdata_in;
            end
        end
    end

    assign bus.busy_out        = busy;
    assign bus.done_out        = done_q;
    assign bus.div_by_zero_out = dz_out_q;
    assign bus.hi_out          = hi_q;
    assign bus.lo_out          = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO register pair.
- It is the writer side of the HI/LO interface that the ALU's MFHI/MFLO path reads.
- Executes MULT, MULTU, DIV, DIVU with a start/busy/done handshake, and accepts MTHI/MTLO writes.
- Sits beside the ALU in the EX stage. The pipeline control stalls on busy_out before issuing MFHI/MFLO or another mul/div.

Parameters:
- DATA_WIDTH, 32: operand width. HI and LO are each DATA_WIDTH bits. Iterative latency is DATA_WIDTH+1 cycles.

Ports:
- clk_in  input  1  rising-edge clock
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  request an operation; sampled only in IDLE
- op_in  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- data1_in  input  DATA_WIDTH  rs operand (multiplicand / dividend)
- data2_in  input  DATA_WIDTH  rt operand (multiplier / divisor)
- hi_we_in  input  1  MTHI write enable
- lo_we_in  input  1  MTLO write enable
- wdata_in  input  DATA_WIDTH  MTHI/MTLO write data
- busy_out  output  1  operation in progress
- done_out  output  1  one-cycle completion pulse
- div_by_zero_out  output  1  one-cycle pulse with done_out when a divide had divisor 0
- hi_out  output  DATA_WIDTH  current HI register
- lo_out  output  DATA_WIDTH  current LO register

Behaviour:
- Reset (async, rst_n_in low):
  - state=IDLE; HI=LO=0; busy_out=0, done_out=0, div_by_zero_out=0; iteration counter=0.
  - Reset mid-operation aborts the operation; no result is written.
- States: IDLE, RUN, FIX.
  - IDLE: start_in=1 at an edge latches op_in and operands, and loads the operand magnitudes (signed ops take abs). Counter=DATA_WIDTH, go to RUN, busy_out=1.
  - RUN: one radix-2 step per cycle. Multiply is shift-add on a 2*DATA_WIDTH product. Divide is restoring, producing one quotient bit per cycle. Counter decrements; when it reaches 0, go to FIX.
  - FIX: sign correction.
    - Signed multiply: negate the product if operand signs differ.
    - Signed divide: quotient negated if signs differ; remainder takes the dividend's sign.
    - At the FIX edge, HI/LO are written, state goes to IDLE, busy_out drops and done_out is 1 for exactly one cycle.
- Latency: start sampled at edge N; busy_out is high for cycles N+1 through N+DATA_WIDTH+1; HI/LO are updated at edge N+DATA_WIDTH+1; done_out is high in the following cycle.
- Results:
  - Multiply: HI=product[2W-1:W], LO=product[W-1:0].
  - Divide: LO=quotient, HI=remainder.
- Divisor 0 (DIV or DIVU):
  - LO=all ones; HI=dividend, unmodified, original sign.
  - div_by_zero_out pulses with done_out.
  - Same latency; no early exit.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- start_in while busy_out=1 is ignored; no queuing.
- hi_we_in/lo_we_in:
  - In IDLE, write HI/LO from wdata_in at the edge.
  - While busy, writes are ignored.
  - Start and a write at the same IDLE edge: the write takes effect and the start is accepted; the operation result later overwrites it.
- hi_out/lo_out are registered and hold their value between updates.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU complete in a single combinational-multiply cycle. Start at edge N writes HI/LO at edge N+1; busy_out is high only in cycle N+1; done_out is high in cycle N+2. Divide is unchanged.
- Undefined: all operations are iterative with DATA_WIDTH+1 latency.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 busy cycles, HI=0xFFFFFFFE, LO=0x00000001; done_out is a single-cycle pulse.
- MULT 0xFFFFFFFD (-3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU 0x64 / 0 -> LO=0xFFFFFFFF, HI=0x64; div_by_zero_out and done_out pulse together.
- MTHI 0x1234 in IDLE -> hi_out=0x1234 next cycle. A second start and an MTLO during busy are both ignored, and the original result is delivered.
- rst_n_in low mid-RUN -> immediately HI=LO=0 and busy_out=0; no done_out. A later MULT 3×4 gives LO=12, HI=0.
